fifo_push_arb: RTL and testbench

//  Round-robin burst arbiter sharing the single push port of the fifo among NREQ producers.

---
 rtl/fifo_push_arb.sv | 124 ++++++++++++
 tb/tb_fifo_push_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_arb.sv
// Round-robin burst arbiter sharing the fifo push port among NREQ producers.
// Optional macro FIFO_ARB_STATS_EN adds per-requester saturating grant counters.
module fifo_push_arb #(
  parameter int NREQ     = 4,
  parameter int DW       = 31,
  parameter int MAXBURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   data,
  output logic [NREQ-1:0]      ack,
  input  logic                 fifo_full,
  output logic                 fifo_push,
  output logic [DW-1:0]        fifo_datain,
  output logic [3:0]           owner,
`ifdef FIFO_ARB_STATS_EN
  output logic [NREQ*16-1:0]   grant_cnt,
`endif
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAXBURST) + 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [IW-1:0]   grant_idx;
  logic            found;

  // Round-robin search starts just after the previous owner and wraps back to it.
  always_comb begin
    grant_idx = last_q;
    found     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req[(int'(last_q) + k) % NREQ]) begin
        found     = 1'b1;
        grant_idx = IW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    fifo_push   = (state_q == BURST) && req[owner_q] && !fifo_full;
    ack         = '0;
    if (fifo_push) ack[owner_q] = 1'b1;
    fifo_datain = data[int'(owner_q)*DW +: DW];
    busy        = (state_q == BURST);
    owner       = 4'(owner_q);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = grant_idx;
          bcnt_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
          bcnt_d  = '0;
        end else if (fifo_push) begin
          if (bcnt_q == BW'(MAXBURST - 1)) begin
            state_d = IDLE;
            last_d  = owner_q;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] gcnt_q [NREQ];
  logic [15:0] gcnt_d [NREQ];

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      gcnt_d[i] = gcnt_q[i];
      if (ack[i] && gcnt_q[i] != 16'hFFFF) gcnt_d[i] = gcnt_q[i] + 16'd1;
      grant_cnt[i*16 +: 16] = gcnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) gcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) gcnt_q[i] <= gcnt_d[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
// Self-checking bench for fifo_push_arb: producer model, cycle model compare, directed scenarios.
module tb_fifo_push_arb;

  localparam int NREQ = 4;
  localparam int DW   = 31;
  localparam int MB   = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*DW-1:0]  data = '0;
  logic [NREQ-1:0]     ack;
  logic                fifo_full = 1'b0;
  logic                fifo_push;
  logic [DW-1:0]       fifo_datain;
  logic [3:0]          owner;
  logic                busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*16-1:0]  grant_cnt;
`endif

  fifo_push_arb #(.NREQ(NREQ), .DW(DW), .MAXBURST(MB)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .data(data),
    .ack(ack),
    .fifo_full(fifo_full),
    .fifo_push(fifo_push),
    .fifo_datain(fifo_datain),
    .owner(owner),
`ifdef FIFO_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Producer state: words still to send and index of the current word.
  int remain [NREQ];
  int wordn  [NREQ];
  logic [NREQ-1:0] ack_s = '0;
  int cyc = 0;
  int push_owner_q [$];
  int push_cycle_q [$];

  // Abstract arbiter model.
  bit m_busy = 0;
  int m_owner = 0;
  int m_last = NREQ - 1;
  int m_cnt = 0;
  int m_gcnt [NREQ];

  function automatic logic [DW-1:0] wordVal(int i, int n);
    return DW'(32'h5A000 + i * 1000 + n);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refreshInputs();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (remain[i] > 0);
      data[i*DW +: DW] = wordVal(i, wordn[i]);
    end
  endtask

  // One clock cycle: consume acks seen last cycle, then drive this cycle's inputs.
  task automatic applyStimulus(input logic r, input logic full);
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ack_s[i] && remain[i] > 0) begin
        remain[i]--;
        wordn[i]++;
      end
    end
    rst = r;
    fifo_full = full;
    refreshInputs();
    cyc++;
  endtask

  task automatic doReset();
    for (int i = 0; i < NREQ; i++) begin
      remain[i] = 0;
      wordn[i] = 0;
    end
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    push_owner_q.delete();
    push_cycle_q.delete();
    cyc = 0;
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0);
  endtask

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    logic exp_push;
    logic [NREQ-1:0] exp_ack;
    if (!rst) begin
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_push", 64'(fifo_push), 64'd0);
      checkOutput("rst_ack", 64'(ack), 64'd0);
      checkOutput("rst_owner", 64'(owner), 64'd0);
`ifdef FIFO_ARB_STATS_EN
      checkOutput("rst_gcnt", 64'(grant_cnt), 64'd0);
      for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
`endif
      m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_cnt = 0;
    end else begin
      exp_push = m_busy && req[m_owner] && !fifo_full;
      exp_ack = '0;
      if (exp_push) exp_ack[m_owner] = 1'b1;
      checkOutput("busy", 64'(busy), 64'(m_busy));
      checkOutput("push", 64'(fifo_push), 64'(exp_push));
      checkOutput("ack", 64'(ack), 64'(exp_ack));
      if (m_busy) checkOutput("owner", 64'(owner), 64'(m_owner));
      if (exp_push) checkOutput("datain", 64'(fifo_datain), 64'(wordVal(m_owner, wordn[m_owner])));
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) begin
        checkOutput("grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_gcnt[i]));
        if (exp_ack[i] && m_gcnt[i] < 65535) m_gcnt[i]++;
      end
`endif
      if (fifo_push) begin
        push_owner_q.push_back(int'(owner));
        push_cycle_q.push_back(cyc);
      end
      if (!m_busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!m_busy && req[(m_last + k) % NREQ]) begin
            m_busy = 1; m_owner = (m_last + k) % NREQ; m_cnt = 0;
          end
        end
      end else if (!req[m_owner]) begin
        m_busy = 0; m_last = m_owner;
      end else if (exp_push) begin
        m_cnt++;
        if (m_cnt == MB) begin
          m_busy = 0; m_last = m_owner; m_cnt = 0;
        end
      end
    end
    ack_s = ack;
  end

  task automatic checkPushes(input string name, input int owners[$], input int cycles[$]);
    checkOutput({name, "_count"}, 64'(push_owner_q.size()), 64'(owners.size()));
    for (int i = 0; i < owners.size() && i < push_owner_q.size(); i++) begin
      checkOutput({name, "_owner"}, 64'(push_owner_q[i]), 64'(owners[i]));
      if (cycles.size() > i) checkOutput({name, "_cycle"}, 64'(push_cycle_q[i]), 64'(cycles[i]));
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      remain[i] = 0; wordn[i] = 0; m_gcnt[i] = 0;
    end

    // Single requester: 4-push burst, one idle cycle, then remaining 2.
    doReset();
    remain[0] = 6;
    runCycles(12);
    checkPushes("single", '{0, 0, 0, 0, 0, 0}, '{2, 3, 4, 5, 7, 8});

    // All four requesting: rotation 0,1,2,3 with one idle gap per burst, three rounds.
    doReset();
    for (int i = 0; i < NREQ; i++) remain[i] = 12;
    runCycles(64);
    checkOutput("rr_total", 64'(push_owner_q.size()), 64'd48);
    if (push_owner_q.size() >= 20) begin
      checkOutput("rr_b0", 64'(push_owner_q[0]), 64'd0);
      checkOutput("rr_b1", 64'(push_owner_q[4]), 64'd1);
      checkOutput("rr_b2", 64'(push_owner_q[8]), 64'd2);
      checkOutput("rr_b3", 64'(push_owner_q[12]), 64'd3);
      checkOutput("rr_b4", 64'(push_owner_q[16]), 64'd0);
      checkOutput("rr_gap", 64'(push_cycle_q[4] - push_cycle_q[3]), 64'd2);
      checkOutput("rr_first", 64'(push_cycle_q[0]), 64'd2);
    end
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) checkOutput("stats_12", 64'(grant_cnt[i*16 +: 16]), 64'd12);
`endif

    // Backpressure: one push, full for three cycles, then three more pushes.
    doReset();
    remain[2] = 4;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("bp_owner", 64'(owner), 64'd2);
    checkOutput("bp_nopush", 64'(fifo_push), 64'd0);
    checkOutput("bp_busy", 64'(busy), 64'd1);
    applyStimulus(1'b1, 1'b1);
    runCycles(5);
    checkPushes("bp", '{2, 2, 2, 2}, '{2, 6, 7, 8});

    // Owner 1 drops after two pushes; requester 3 takes over after the idle cycle.
    doReset();
    remain[1] = 2;
    remain[3] = 3;
    runCycles(10);
    checkPushes("drop", '{1, 1, 3, 3, 3}, '{2, 3, 6, 7, 8});

    // Reset mid-burst aborts at once; then 3 alone, then 0 and 3 together.
    doReset();
    remain[2] = 4;
    runCycles(3);
    remain[2] = 0;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("mid_rst_push", 64'(fifo_push), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    push_owner_q.delete();
    push_cycle_q.delete();
    cyc = 0;
    remain[3] = 2;
    runCycles(6);
    remain[0] = 1;
    remain[3] = 1;
    runCycles(8);
    checkPushes("post_rst", '{3, 3, 0, 3}, '{2, 3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
